// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(7,4) serial receiver.
// Codeword vectors are 0-based: bit i holds code position c(i+1).
package hamming_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  localparam int unsigned CwP1 = 0;
  localparam int unsigned CwP2 = 1;
  localparam int unsigned CwD1 = 2;
  localparam int unsigned CwP3 = 3;
  localparam int unsigned CwD2 = 4;
  localparam int unsigned CwD3 = 5;
  localparam int unsigned CwD4 = 6;

  localparam int unsigned CwBits = 7;

endpackage

// File: rtl/tt_um_hamming74_correct.sv
// Combinational Hamming(7,4) syndrome decode and single-bit correction.
module tt_um_hamming74_correct
  import hamming_pkg::*;
(
  input  logic [CwBits-1:0] cw_i,
  output logic [3:0]        data_o,
  output logic [2:0]        syndrome_o,
  output logic              corrected_o
);

  logic [2:0]        syn;
  logic [CwBits-1:0] fixed;

  always_comb begin
    syn[0] = cw_i[CwP1] ^ cw_i[CwD1] ^ cw_i[CwD2] ^ cw_i[CwD4];
    syn[1] = cw_i[CwP2] ^ cw_i[CwD1] ^ cw_i[CwD3] ^ cw_i[CwD4];
    syn[2] = cw_i[CwP3] ^ cw_i[CwD2] ^ cw_i[CwD3] ^ cw_i[CwD4];
    fixed  = cw_i;
    // A nonzero syndrome names the 1-based position of the flipped bit.
    if (syn != 3'd0) begin
      fixed[syn - 3'd1] = ~cw_i[syn - 3'd1];
    end
  end

  assign data_o      = {fixed[CwD4], fixed[CwD3], fixed[CwD2], fixed[CwD1]};
  assign syndrome_o  = syn;
  assign corrected_o = (syn != 3'd0);

endmodule

// File: rtl/tt_um_hamming_rx_ctrl.sv
// Serial Hamming(7,4) receiver: start/7 code bits/stop framing, correction,
// and a single-entry valid/ready holding register with overrun reporting.
module tt_um_hamming_rx_ctrl
  import hamming_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       rx_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic [2:0] out_syndrome,
  output logic       out_corrected,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned TW       = $clog2(CLKS_PER_BIT);
  localparam int unsigned HalfLast = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned BitLast  = CLKS_PER_BIT - 1;

  rx_state_e         state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        idx_q, idx_d;
  logic [CwBits-1:0] cw_q, cw_d;
  logic              rx_meta_q, rxs_q;

  logic              out_valid_q, out_valid_d;
  logic [3:0]        out_data_q, out_data_d;
  logic [2:0]        out_syn_q, out_syn_d;
  logic              out_corr_q, out_corr_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  logic              frame_done, frame_bad;
  logic [3:0]        fix_data;
  logic [2:0]        fix_syn;
  logic              fix_corr;

  tt_um_hamming74_correct u_correct (
    .cw_i        (cw_q),
    .data_o      (fix_data),
    .syndrome_o  (fix_syn),
    .corrected_o (fix_corr)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    idx_d      = idx_q;
    cw_d       = cw_q;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    if (!ena) begin
      state_d = StIdle;
      timer_d = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          timer_d = '0;
          if (!rxs_q) state_d = StStart;
        end
        StStart: begin
          if (timer_q == TW'(HalfLast)) begin
            timer_d = '0;
            idx_d   = '0;
            state_d = rxs_q ? StIdle : StData;
          end
        end
        StData: begin
          if (timer_q == TW'(BitLast)) begin
            timer_d     = '0;
            cw_d[idx_q] = rxs_q;
            if (idx_q == 3'd6) state_d = StStop;
            else               idx_d   = idx_q + 3'd1;
          end
        end
        StStop: begin
          if (timer_q == TW'(BitLast)) begin
            timer_d    = '0;
            state_d    = StIdle;
            frame_done = rxs_q;
            frame_bad  = ~rxs_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_syn_d   = out_syn_q;
    out_corr_d  = out_corr_q;
    frame_err_d = frame_bad;
    overrun_d   = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (frame_done) begin
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        // Covers both an empty register and a same-edge handshake.
        out_valid_d = 1'b1;
        out_data_d  = fix_data;
        out_syn_d   = fix_syn;
        out_corr_d  = fix_corr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      idx_q       <= '0;
      cw_q        <= '0;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_syn_q   <= '0;
      out_corr_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      cw_q        <= cw_d;
      rx_meta_q   <= rx_in;
      rxs_q       <= rx_meta_q;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_syn_q   <= out_syn_d;
      out_corr_q  <= out_corr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_syndrome  = out_syn_q;
  assign out_corrected = out_corr_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_tt_um_hamming_rx_ctrl.sv
// Self-checking bench: Hamming(7,4) model plus an event scoreboard checked
// every cycle, and directed scenarios with literal expectations.
module tb_tt_um_hamming_rx_ctrl;

  localparam int unsigned CPB = 8;

  logic       clk = 1'b0;
  logic       rst, ena, rx_in, out_ready;
  logic       out_valid, out_corrected, frame_err, overrun, busy;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;

  tt_um_hamming_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .rx_in         (rx_in),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_syndrome  (out_syndrome),
    .out_corrected (out_corrected),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       good;
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_loads = 0, n_ferr = 0, n_ovr = 0;
  logic [3:0] last_data;
  logic [2:0] last_syn;
  logic       last_corr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Codeword held as c[7:1]; parity at 2^j covers every position with bit j set.
  function automatic logic [7:1] encode(input logic [3:0] d);
    logic [7:1] c;
    logic       p;
    c    = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    for (int j = 0; j < 3; j++) begin
      p = 1'b0;
      for (int k = 1; k <= 7; k++) if (k[j] && k != (1 << j)) p ^= c[k];
      c[1 << j] = p;
    end
    return c;
  endfunction

  function automatic exp_t decode(input logic [7:1] cin);
    exp_t       e;
    logic [7:1] c;
    logic [2:0] s;
    c = cin;
    s = 3'd0;
    for (int k = 1; k <= 7; k++) if (c[k]) s ^= k[2:0];
    if (s != 3'd0) c[s] = ~c[s];
    e.good = 1'b1;
    e.data = {c[7], c[6], c[5], c[3]};
    e.syn  = s;
    e.corr = (s != 3'd0);
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    tick(CPB);
  endtask

  // ready_at >= 0 raises out_ready on that cycle of the stop bit.
  task automatic send_frame(input logic [7:1] c, input logic stop, input int ready_at);
    exp_t e;
    send_bit(1'b0);
    for (int k = 1; k <= 7; k++) send_bit(c[k]);
    e = decode(c);
    if (!stop) e = '0;
    exp_q.push_back(e);
    rx_in = stop;
    for (int i = 0; i < int'(CPB); i++) begin
      if (i == ready_at) out_ready = 1'b1;
      tick(1);
    end
    rx_in = 1'b1;
  endtask

  // Start bit plus three full code bits, then drop into the fourth.
  task automatic send_partial(input logic [7:1] c);
    send_bit(1'b0);
    for (int k = 1; k <= 3; k++) send_bit(c[k]);
    rx_in = c[4];
    tick(CPB / 2);
  endtask

  logic       pv, pr, pc;
  logic [3:0] pd;
  logic [2:0] ps;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (frame_err) begin
        n_ferr++;
        if (exp_q.size() == 0) chk("unexpected_frame_err", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("frame_err_kind", e.good, 1'b0);
        end
      end
      if (overrun) begin
        n_ovr++;
        chk("overrun_while_full", pv && !pr, 1'b1);
        if (exp_q.size() == 0) chk("unexpected_overrun", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("overrun_kind", e.good, 1'b1);
        end
      end
      if (out_valid && (!pv || pr)) begin
        n_loads++;
        last_data = out_data;
        last_syn  = out_syndrome;
        last_corr = out_corrected;
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("result_kind", e.good, 1'b1);
          chk("result_data", out_data, e.data);
          chk("result_syndrome", out_syndrome, e.syn);
          chk("result_corrected", out_corrected, e.corr);
        end
      end
      if (pv && !pr) begin
        chk("held_valid", out_valid, 1'b1);
        chk("held_bundle", {out_data, out_syndrome, out_corrected}, {pd, ps, pc});
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      ps = out_syndrome;
      pc = out_corrected;
    end
  end

  localparam int NVEC = 5;
  logic [3:0] vec_d[NVEC] = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h6};
  int         vec_f[NVEC] = '{0, 7, 3, 1, 2};

  initial begin
    logic [7:1] c;
    int l0, f0, o0;
    rst = 1'b1; ena = 1'b1; rx_in = 1'b1; out_ready = 1'b1;
    tick(3);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_out_syndrome", out_syndrome, 3'd0);
    chk("rst_out_corrected", out_corrected, 1'b0);
    chk("rst_flags", {frame_err, overrun}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(4);

    chk("model_encode_1011", encode(4'b1011), 7'b1010101);
    c = encode(4'b1011);
    c[5] = ~c[5];
    chk("model_decode_c5", decode(c), {1'b1, 4'b1011, 3'd5, 1'b1});

    // Clean frame, then the same frame with c5 flipped.
    l0 = n_loads;
    send_frame(encode(4'b1011), 1'b1, -1);
    tick(4);
    chk("clean_loads", n_loads - l0, 1);
    chk("clean_data", last_data, 4'b1011);
    chk("clean_syndrome", last_syn, 3'd0);
    chk("clean_corrected", last_corr, 1'b0);
    chk("clean_valid_cleared", out_valid, 1'b0);
    send_frame(c, 1'b1, -1);
    tick(4);
    chk("c5_data", last_data, 4'b1011);
    chk("c5_syndrome", last_syn, 3'd5);
    chk("c5_corrected", last_corr, 1'b1);

    // Bad stop bit.
    l0 = n_loads; f0 = n_ferr;
    send_frame(encode(4'b1011), 1'b0, -1);
    tick(CPB);
    chk("stop0_frame_err", n_ferr - f0, 1);
    chk("stop0_no_result", n_loads - l0, 0);
    chk("stop0_valid", out_valid, 1'b0);

    for (int v = 0; v < NVEC; v++) begin
      c = encode(vec_d[v]);
      if (vec_f[v] != 0) c[vec_f[v]] = ~c[vec_f[v]];
      send_frame(c, 1'b1, -1);
      tick(2);
      chk("vec_data", last_data, vec_d[v]);
      chk("vec_syndrome", last_syn, vec_f[v]);
    end

    // Back-to-back frames into a full register.
    out_ready = 1'b0;
    l0 = n_loads; o0 = n_ovr;
    send_frame(encode(4'b1011), 1'b1, -1);
    send_frame(encode(4'b0000), 1'b1, -1);
    tick(4);
    chk("ovr_valid_held", out_valid, 1'b1);
    chk("ovr_data_held", out_data, 4'b1011);
    chk("ovr_pulses", n_ovr - o0, 1);
    out_ready = 1'b1;
    tick(30);
    chk("ovr_single_result", n_loads - l0, 1);
    chk("ovr_drained", out_valid, 1'b0);

    // Sweep out_ready across the completion edge; offset 6 is the same edge.
    for (int off = 4; off <= 8; off++) begin
      out_ready = 1'b0;
      l0 = n_loads; o0 = n_ovr;
      send_frame(encode(4'h3), 1'b1, -1);
      send_frame(encode(4'hC), 1'b1, off);
      out_ready = 1'b1;
      tick(4);
      if (off == 6) begin
        chk("same_edge_no_overrun", n_ovr - o0, 0);
        chk("same_edge_loads", n_loads - l0, 2);
        chk("same_edge_data", last_data, 4'hC);
      end
      tick(16);
    end

    // False start.
    f0 = n_ferr; l0 = n_loads;
    rx_in = 1'b0;
    tick(3);
    rx_in = 1'b1;
    chk("false_start_busy", busy, 1'b1);
    tick(6);
    chk("false_start_idle", busy, 1'b0);
    tick(CPB * 2);
    chk("false_start_no_flags", {n_ferr - f0, n_loads - l0}, 0);

    // Abandon via ena, then via rst, each followed by a good frame.
    for (int m = 0; m < 2; m++) begin
      f0 = n_ferr; l0 = n_loads;
      send_partial(encode(4'h9));
      if (m == 0) ena = 1'b0;
      else        rst = 1'b1;
      rx_in = 1'b1;
      tick(2);
      ena = 1'b1; rst = 1'b0;
      chk("abandon_idle", busy, 1'b0);
      tick(CPB * 2);
      send_frame(encode(4'h6), 1'b1, -1);
      tick(4);
      chk("abandon_one_result", n_loads - l0, 1);
      chk("abandon_data", last_data, 4'h6);
      chk("abandon_no_frame_err", n_ferr - f0, 0);
    end

    tick(20);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
